seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the BCD-to-7-segment display path. Samples a multiplexed, common-anode 7-segment bus (active-low segments a-g, active-low digit anodes) and reconstructs the per-digit BCD value. Flags blank and illegal patterns, and signals when a full display scan has been captured. Used for display loopback checking on-board and as a self-checking monitor in the ALU display benches.

---
 rtl/seg7_scan_decoder.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder : recovers per-digit BCD values from a multiplexed,
//                     common-anode (active-low) 7-segment bus.
// Revision 1.0
// ============================================================================
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_seg,
  input  logic [N_DIGITS-1:0]   i_an,
  output logic [4*N_DIGITS-1:0] o_bcd,
  output logic [N_DIGITS-1:0]   o_valid,
  output logic [N_DIGITS-1:0]   o_blank,
  output logic [N_DIGITS-1:0]   o_err,
  output logic                  o_update,
  output logic                  o_frame_done,
  output logic                  o_collision
);

  localparam int                c_run_w   = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_run_w-1:0] c_run_max = c_run_w'(STABLE_CYCLES);
  localparam logic [N_DIGITS-1:0] c_one   = N_DIGITS'(1);

  logic [6:0]            seg_q;
  logic [N_DIGITS-1:0]   an_q;
  logic [c_run_w-1:0]    run_q, run_d;
  logic                  captured_q, captured_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d, blank_q, blank_d, err_q, err_d;
  logic                  update_q, update_d, frame_q, frame_d;

  logic [N_DIGITS-1:0]   w_in_sel, w_sel, w_seen_next;
  logic                  w_in_active, w_active, w_change, w_capture;
  logic [5:0]            w_dec;

  // Returns {bcd, valid, blank}; a pattern that is neither is an error.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = {4'd0, 2'b10};
      7'b1111001: decode = {4'd1, 2'b10};
      7'b0100100: decode = {4'd2, 2'b10};
      7'b0110000: decode = {4'd3, 2'b10};
      7'b0011001: decode = {4'd4, 2'b10};
      7'b0010010: decode = {4'd5, 2'b10};
      7'b0000010: decode = {4'd6, 2'b10};
      7'b1111000: decode = {4'd7, 2'b10};
      7'b0000000: decode = {4'd8, 2'b10};
      7'b0010000: decode = {4'd9, 2'b10};
      7'b1111111: decode = {4'hF, 2'b01};
      default:    decode = {4'hF, 2'b00};
    endcase
  endfunction

  assign w_in_sel    = ~i_an;
  assign w_in_active = (w_in_sel != '0) && ((w_in_sel & (w_in_sel - c_one)) == '0);
  assign w_sel       = ~an_q;
  assign w_active    = (w_sel != '0) && ((w_sel & (w_sel - c_one)) == '0);
  assign o_collision = (w_sel != '0) && !w_active;
  assign w_change    = {i_an, i_seg} != {an_q, seg_q};
  assign w_capture   = w_active && (run_q == c_run_max) && !captured_q;
  assign w_dec       = decode(seg_q);
  assign w_seen_next = seen_q | w_sel;

  // The run counter tracks how long the sample now entering the input
  // register will have been stable, so the capture lands STABLE_CYCLES
  // edges after that sample was first registered.
  always_comb begin
    run_d      = run_q;
    captured_d = w_change ? 1'b0 : (captured_q | w_capture);
    seen_d     = seen_q;
    bcd_d      = bcd_q;
    valid_d    = valid_q;
    blank_d    = blank_q;
    err_d      = err_q;
    update_d   = w_capture;
    frame_d    = 1'b0;

    if (!w_in_active)           run_d = '0;
    else if (w_change)          run_d = c_run_w'(1);
    else if (run_q != c_run_max) run_d = run_q + c_run_w'(1);

    if (w_capture) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (w_sel[k]) begin
          bcd_d[4*k +: 4] = w_dec[5:2];
          valid_d[k]      = w_dec[1];
          blank_d[k]      = w_dec[0];
          err_d[k]        = ~w_dec[1] & ~w_dec[0];
        end
      end
      if (&w_seen_next) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = w_seen_next;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seg_q      <= 7'b1111111;
      an_q       <= '1;
      run_q      <= '0;
      captured_q <= 1'b0;
      seen_q     <= '0;
      bcd_q      <= '1;
      valid_q    <= '0;
      blank_q    <= '0;
      err_q      <= '0;
      update_q   <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      seg_q      <= i_seg;
      an_q       <= i_an;
      run_q      <= run_d;
      captured_q <= captured_d;
      seen_q     <= seen_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      update_q   <= update_d;
      frame_q    <= frame_d;
    end
  end

  assign o_bcd        = bcd_q;
  assign o_valid      = valid_q;
  assign o_blank      = blank_q;
  assign o_err        = err_q;
  assign o_update     = update_q;
  assign o_frame_done = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_decoder : directed stimulus with a queued expected-capture
//                        scoreboard checked by an independent monitor.
// Revision 1.0
// ============================================================================
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic [3:0]  valid, blank, err;
  logic        update, frame_done, collision;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_seg        (seg),
    .i_an         (an),
    .o_bcd        (bcd),
    .o_valid      (valid),
    .o_blank      (blank),
    .o_err        (err),
    .o_update     (update),
    .o_frame_done (frame_done),
    .o_collision  (collision)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        frame;
  } exp_t;

  exp_t q[$];
  exp_t model;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_upd    = 0;
  int   n_frame  = 0;
  int   n_coll   = 0;
  int   u0, f0, c0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    model.bcd   = 16'hFFFF;
    model.valid = 4'b0;
    model.blank = 4'b0;
    model.err   = 4'b0;
    model.frame = 1'b0;
  endtask

  // kind: 0 = legal digit, 1 = blank, 2 = illegal
  task automatic expect_capture(input int k, input logic [3:0] code, input int kind,
                                input logic frame);
    model.bcd[4*k +: 4] = code;
    model.valid[k]      = (kind == 0);
    model.blank[k]      = (kind == 1);
    model.err[k]        = (kind == 2);
    model.frame         = frame;
    q.push_back(model);
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (collision) n_coll++;
    if (frame_done) begin
      n_frame++;
      check("frame_with_update", {31'b0, update}, 32'd1);
    end
    if (update) begin
      n_upd++;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_update: got update with bcd %0h, expected no update", bcd);
      end else begin
        e = q.pop_front();
        check("sb_bcd",   {16'b0, bcd},        {16'b0, e.bcd});
        check("sb_valid", {28'b0, valid},      {28'b0, e.valid});
        check("sb_blank", {28'b0, blank},      {28'b0, e.blank});
        check("sb_err",   {28'b0, err},        {28'b0, e.err});
        check("sb_frame", {31'b0, frame_done}, {31'b0, e.frame});
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd",   {16'b0, bcd},        32'hFFFF);
    check("rst_valid", {28'b0, valid},      32'h0);
    check("rst_blank", {28'b0, blank},      32'h0);
    check("rst_err",   {28'b0, err},        32'h0);
    check("rst_pulses", {29'b0, update, frame_done, collision}, 32'h0);
    rst = 1'b0;

    // 2: digit 0 shows 2, capture exactly STABLE_CYCLES edges later
    u0 = n_upd;
    expect_capture(0, 4'd2, 0, 1'b0);
    an  = 4'b1110;
    seg = 7'b0100100;
    repeat (4) @(posedge clk);
    #1;
    check("t2_no_early_update", {31'b0, update}, 32'd0);
    @(posedge clk);
    #1;
    check("t2_update_at_latency", {31'b0, update}, 32'd1);
    check("t2_digit0", {28'b0, bcd[3:0]}, 32'd2);
    check("t2_valid0", {31'b0, valid[0]}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t2_update_count", n_upd - u0, 32'd1);

    // 3: short 9 transient on digit 1 must not be captured
    u0 = n_upd;
    dwell(4'b1101, 7'b0010000, 2);
    expect_capture(1, 4'd1, 0, 1'b0);
    dwell(4'b1101, 7'b1111001, 6);
    check("t3_update_count", n_upd - u0, 32'd1);

    // 4: full scan with legal, blank and illegal patterns
    u0 = n_upd;
    f0 = n_frame;
    expect_capture(0, 4'd1, 0, 1'b0);
    dwell(4'b1110, 7'b1111001, 6);
    expect_capture(1, 4'd9, 0, 1'b0);
    dwell(4'b1101, 7'b0010000, 6);
    expect_capture(2, 4'hF, 1, 1'b0);
    dwell(4'b1011, 7'b1111111, 6);
    expect_capture(3, 4'hF, 2, 1'b1);
    dwell(4'b0111, 7'b0101010, 6);
    check("t4_bcd",   {16'b0, bcd},   32'hFF91);
    check("t4_valid", {28'b0, valid}, 32'b0011);
    check("t4_blank", {28'b0, blank}, 32'b0100);
    check("t4_err",   {28'b0, err},   32'b1000);
    check("t4_update_count", n_upd - u0, 32'd4);
    check("t4_frame_count",  n_frame - f0, 32'd1);

    // 5: anode collision, then idle bus
    u0 = n_upd;
    f0 = n_frame;
    c0 = n_coll;
    dwell(4'b1100, 7'b0000000, 6);
    dwell(4'b1111, 7'b1111111, 6);
    check("t5_collision_count", n_coll - c0, 32'd6);
    check("t5_update_count", n_upd - u0, 32'd0);
    check("t5_frame_count",  n_frame - f0, 32'd0);
    check("t5_bcd_held",     {16'b0, bcd}, 32'hFF91);
    check("t5_flags_held",   {20'b0, valid, blank, err}, {20'b0, 12'b0011_0100_1000});

    // 6: reset interrupts a dwell; a full run is needed afterwards
    u0 = n_upd;
    dwell(4'b1110, 7'b1111000, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_rst_bcd",   {16'b0, bcd},   32'hFFFF);
    check("t6_rst_valid", {28'b0, valid}, 32'h0);
    model_reset();
    rst = 1'b0;
    expect_capture(0, 4'd7, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_early_update", {31'b0, update}, 32'd0);
    @(posedge clk);
    #1;
    check("t6_update_at_latency", {31'b0, update}, 32'd1);
    check("t6_bcd",   {16'b0, bcd},   32'hFFF7);
    check("t6_valid", {28'b0, valid}, 32'b0001);
    repeat (2) @(posedge clk);
    #1;
    check("t6_update_count", n_upd - u0, 32'd1);

    check("sb_queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
